save_stream_engine: RTL and testbench

// Parametrised save engine: moves a block of words from one of NUM_BANKS on-chip buffer banks to DRAM.

---
 rtl/save_stream_engine.sv | 193 +++++++++++++++++++
 tb/tb_save_stream_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/save_stream_engine.sv
// save_stream_engine
// Moves a block of words from one selected on-chip buffer bank to DRAM. A save instruction is
// decoded on ap_start, the AXI write master is launched (wm_start/wm_addr/wm_size) and buffer
// read data is streamed to it over AXI-stream. Bank reads are credit limited so every word in
// flight always has a slot in the local FIFO, which lets reads overlap stream backpressure.
//
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   ap_start/done/busy     instruction handshake with ctrl
//   err_bad_group          sticky until next accepted start: group field not one-hot
//   ctrl_addr_offset       DRAM base added to instruction address
//   ctrl_instruction       [127:96] dram addr, [95:80] bytes, [63:48] len, [47:32] buf addr,
//                          [5:0] group
//   wm_start/addr/size     write-master launch; wm_done completion pulse from it
//   buf_avalid/addr        per-bank read request, shared read address
//   buf_valid/data         per-bank read return, bank k data at [k*DATA_W +: DATA_W]
//   m_axis_*               stream to the write master (first-word-fall-through)
module save_stream_engine #(
    parameter int unsigned INST_W     = 128,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned XFER_W     = 32,
    parameter int unsigned BUF_AW     = 11,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_busy,
    output logic                        err_bad_group,
    input  logic [ADDR_W-1:0]           ctrl_addr_offset,
    input  logic [INST_W-1:0]           ctrl_instruction,
    output logic                        wm_start,
    output logic [ADDR_W-1:0]           wm_addr,
    output logic [XFER_W-1:0]           wm_size,
    input  logic                        wm_done,
    output logic [NUM_BANKS-1:0]        buf_avalid,
    output logic [BUF_AW-1:0]           buf_addr,
    input  logic [NUM_BANKS-1:0]        buf_valid,
    input  logic [NUM_BANKS*DATA_W-1:0] buf_data,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [5:0] BANK_MASK = 6'((64'd1 << NUM_BANKS) - 64'd1);

    typedef enum logic [2:0] {StIdle, StLaunch, StStream, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [XFER_W-1:0]     size_q;
    logic [NUM_BANKS-1:0]  sel_q;
    logic [BUF_AW:0]       cur_q, end_q;
    logic [15:0]           len_q, popped_q;
    logic [CNT_W-1:0]      out_q, count_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  err_q, done_seen_q;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];

    // Instruction fields
    logic [31:0] inst_addr;
    logic [15:0] inst_bytes, inst_len;
    logic [5:0]  inst_group;
    logic        group_ok, start_ok, unused_inst;

    assign inst_addr   = ctrl_instruction[127:96];
    assign inst_bytes  = ctrl_instruction[95:80];
    assign inst_len    = ctrl_instruction[63:48];
    assign inst_group  = ctrl_instruction[5:0];
    assign unused_inst = ^ctrl_instruction;

    // Exactly one bit set, and nothing above the implemented banks
    assign group_ok = ((inst_group & ~BANK_MASK) == 6'd0) && $onehot(inst_group & BANK_MASK);
    assign start_ok = (state_q == StIdle) && ap_start;

    // Datapath control
    logic              issue, push, pop;
    logic [CNT_W:0]    credit_used;
    logic [DATA_W-1:0] rd_data;

    // Words requested but not yet popped; bounded by FIFO_DEPTH so a push always finds a slot
    assign credit_used = (CNT_W + 1)'(out_q) + (CNT_W + 1)'(count_q);
    assign issue = (state_q == StStream) && (cur_q < end_q)
                   && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    // Only returns for reads this engine has outstanding are accepted
    assign push  = (state_q == StStream) && (|(buf_valid & sel_q)) && (out_q != '0);
    assign pop   = (count_q != '0) && m_axis_tready;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (sel_q[k]) rd_data = rd_data | buf_data[k*DATA_W +: DATA_W];
        end
    end

    // FSM next state and control outputs
    always_comb begin
        state_d  = state_q;
        ap_done  = 1'b0;
        ap_busy  = 1'b0;
        wm_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    if (!group_ok || inst_bytes == 16'd0) state_d = StDone;
                    else                                  state_d = StLaunch;
                end
            end
            StLaunch: begin
                ap_busy  = 1'b1;
                wm_start = 1'b1;
                state_d  = StStream;
            end
            StStream: begin
                ap_busy = 1'b1;
                if (cur_q == end_q && out_q == '0 && count_q == '0 && popped_q == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                ap_busy = 1'b1;
                if (wm_done || done_seen_q) state_d = StDone;
            end
            StDone: begin
                ap_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            size_q      <= '0;
            sel_q       <= '0;
            cur_q       <= '0;
            end_q       <= '0;
            len_q       <= '0;
            popped_q    <= '0;
            out_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q      <= ctrl_addr_offset + ADDR_W'(inst_addr);
                size_q      <= XFER_W'(inst_bytes);
                sel_q       <= inst_group[NUM_BANKS-1:0];
                cur_q       <= {1'b0, ctrl_instruction[32 +: BUF_AW]};
                // One extra bit so a block crossing the top of the bank does not end early
                end_q       <= {1'b0, ctrl_instruction[32 +: BUF_AW]} + (BUF_AW + 1)'(inst_len);
                len_q       <= inst_len;
                popped_q    <= '0;
                err_q       <= !group_ok;
                done_seen_q <= 1'b0;
            end else begin
                if (issue) cur_q <= cur_q + 1'b1;
                if (pop)   popped_q <= popped_q + 16'd1;
                // wm_done may beat the last stream beat; remember it for DRAIN
                if (wm_done && (state_q == StLaunch || state_q == StStream)) done_seen_q <= 1'b1;
            end
            if (issue && !push)      out_q <= out_q + 1'b1;
            else if (!issue && push) out_q <= out_q - 1'b1;
            if (push && !pop)        count_q <= count_q + 1'b1;
            else if (!push && pop)   count_q <= count_q - 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= rd_data;
    end

    assign err_bad_group = err_q;
    assign wm_addr       = addr_q;
    assign wm_size       = size_q;
    assign buf_avalid    = issue ? sel_q : '0;
    assign buf_addr      = cur_q[BUF_AW-1:0];
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_save_stream_engine.sv
module tb_save_stream_engine;

    localparam int NB = 4;
    localparam int DW = 512;

    logic            aclk = 1'b0;
    logic            areset;
    logic            ap_start, ap_done, ap_busy, err_bad_group;
    logic [63:0]     ctrl_addr_offset;
    logic [127:0]    ctrl_instruction;
    logic            wm_start, wm_done;
    logic [63:0]     wm_addr;
    logic [31:0]     wm_size;
    logic [NB-1:0]   buf_avalid, buf_valid;
    logic [10:0]     buf_addr;
    logic [NB*DW-1:0] buf_data;
    logic            m_axis_tvalid, m_axis_tready;
    logic [DW-1:0]   m_axis_tdata;

    always #5 aclk = ~aclk;

    save_stream_engine dut (
        .aclk             (aclk),
        .areset           (areset),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_busy          (ap_busy),
        .err_bad_group    (err_bad_group),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_instruction (ctrl_instruction),
        .wm_start         (wm_start),
        .wm_addr          (wm_addr),
        .wm_size          (wm_size),
        .wm_done          (wm_done),
        .buf_avalid       (buf_avalid),
        .buf_addr         (buf_addr),
        .buf_valid        (buf_valid),
        .buf_data         (buf_data),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer bank contents: a fixed function of bank, address and a per-run salt
    logic [31:0] salt;
    function automatic logic [DW-1:0] word(input int b, input logic [10:0] a, input logic [31:0] s);
        logic [31:0] h;
        h = (32'(b) << 28) ^ (32'(a) * 32'h9E37) ^ s;
        return {16{h}};
    endfunction

    // Bank model: fixed read latency 'lat', plus junk valids on unselected banks
    int          lat;
    int          sel_bank;
    bit          noise_en;
    logic [7:0]  pv [NB];
    logic [10:0] pa [NB][8];
    logic [NB-1:0] noise_v;
    logic [31:0] noise_d;

    always @(posedge aclk) begin
        for (int b = 0; b < NB; b++) begin
            for (int i = 7; i > 0; i--) begin
                pv[b][i] <= areset ? 1'b0 : pv[b][i-1];
                pa[b][i] <= pa[b][i-1];
            end
            pv[b][0] <= areset ? 1'b0 : buf_avalid[b];
            pa[b][0] <= buf_addr;
        end
        noise_v <= noise_en ? NB'($urandom) : '0;
        noise_d <= $urandom;
    end

    always_comb begin
        buf_valid = '0;
        buf_data  = '0;
        for (int b = 0; b < NB; b++) begin
            if (pv[b][lat-1] === 1'b1) begin
                buf_valid[b] = 1'b1;
                buf_data[b*DW +: DW] = word(b, pa[b][lat-1], salt);
            end else if (noise_v[b] && b != sel_bank) begin
                buf_valid[b] = 1'b1;
                buf_data[b*DW +: DW] = {16{noise_d}};
            end
        end
    end

    // Reference: the ordered addresses to read and beats to stream for the current instruction
    logic [10:0]   exp_addr [$];
    logic [DW-1:0] exp_beat [$];
    int n_start, n_done, n_reads, n_beats, n_wrong, max_infl;

    task automatic sample();
        if (wm_start) n_start++;
        if (ap_done)  n_done++;
        if (|buf_avalid) begin
            if (buf_avalid !== NB'(1 << sel_bank)) n_wrong++;
            else begin
                n_reads++;
                check("read_expected", exp_addr.size() != 0, 1'b1);
                if (exp_addr.size() != 0) check("read_addr", buf_addr, exp_addr.pop_front());
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            n_beats++;
            check("beat_expected", exp_beat.size() != 0, 1'b1);
            if (exp_beat.size() != 0) check("beat_data", m_axis_tdata, exp_beat.pop_front());
        end
        if (n_reads - n_beats > max_infl) max_infl = n_reads - n_beats;
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_op(input logic [5:0] grp, input logic [10:0] baddr, input int len,
                            input int bytes, input logic [31:0] daddr, input logic [63:0] off,
                            input bit launch);
        logic [10:0] a;
        sel_bank = 0;
        for (int b = 0; b < NB; b++) if (grp[b]) sel_bank = b;
        exp_addr.delete();
        exp_beat.delete();
        if (launch) begin
            for (int i = 0; i < len; i++) begin
                a = 11'(int'(baddr) + i);
                exp_addr.push_back(a);
                exp_beat.push_back(word(sel_bank, a, salt));
            end
        end
        n_start = 0; n_done = 0; n_reads = 0; n_beats = 0; n_wrong = 0; max_infl = 0;
        ctrl_instruction          = '0;
        ctrl_instruction[127:96]  = daddr;
        ctrl_instruction[95:80]   = 16'(bytes);
        ctrl_instruction[63:48]   = 16'(len);
        ctrl_instruction[47:32]   = 16'(baddr);
        ctrl_instruction[5:0]     = grp;
        ctrl_addr_offset          = off;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic run_op(input logic [5:0] grp, input logic [10:0] baddr, input int len,
                          input int bytes, input logic [31:0] daddr, input logic [63:0] off,
                          input int rmode, input bit early, input bit launch, input bit bad);
        int cyc;
        int pause;
        bit sent;
        start_op(grp, baddr, len, bytes, daddr, off, launch);
        if (!launch) begin
            tick();
            check("nolaunch_done", n_done, 1);
        end else begin
            cyc = 0; pause = 0; sent = 0;
            while ((n_beats < len || n_reads < len) && cyc < 3000) begin
                case (rmode)
                    0: m_axis_tready = 1'b1;
                    1: m_axis_tready = 1'($urandom_range(0, 1));
                    default: begin
                        if (n_beats >= 3 && pause < 10) begin
                            m_axis_tready = 1'b0;
                            pause++;
                        end else m_axis_tready = 1'b1;
                    end
                endcase
                if (early && !sent && n_beats >= len / 2) begin
                    wm_done = 1'b1;
                    sent = 1'b1;
                end else wm_done = 1'b0;
                tick();
                cyc++;
            end
            wm_done = 1'b0;
            m_axis_tready = 1'b1;
            check("beat_count", n_beats, len);
            check("read_count", n_reads, len);
            if (!sent) begin
                tick();
                tick();
                check("done_before_wm_done", n_done, 0);
                wm_done = 1'b1;
                tick();
                check("done_same_cycle", n_done, 0);
                wm_done = 1'b0;
                tick();
                check("done_latency", n_done, 1);
            end else begin
                cyc = 0;
                while (n_done == 0 && cyc < 100) begin
                    tick();
                    cyc++;
                end
            end
        end
        repeat (4) tick();
        check("done_pulses", n_done, 1);
        check("wm_start_count", n_start, launch ? 1 : 0);
        check("reads_total", n_reads, launch ? len : 0);
        check("wrong_bank_reads", n_wrong, 0);
        check("credit_bound", max_infl <= 8, 1'b1);
        check("err_bad_group", err_bad_group, bad);
        check("busy_after", ap_busy, 1'b0);
        check("wm_addr", wm_addr, off + 64'(daddr));
        check("wm_size", wm_size, 32'(bytes[15:0]));
    endtask

    initial begin
        areset = 1'b1;
        ap_start = 1'b0;
        wm_done = 1'b0;
        m_axis_tready = 1'b1;
        ctrl_addr_offset = '0;
        ctrl_instruction = '0;
        lat = 2;
        sel_bank = 0;
        noise_en = 1'b0;
        salt = $urandom;
        n_start = 0; n_done = 0; n_reads = 0; n_beats = 0; n_wrong = 0; max_infl = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ap_done", ap_done, 1'b0);
        check("rst_ap_busy", ap_busy, 1'b0);
        check("rst_err", err_bad_group, 1'b0);
        check("rst_wm_start", wm_start, 1'b0);
        check("rst_wm_addr", wm_addr, 64'd0);
        check("rst_wm_size", wm_size, 32'd0);
        check("rst_avalid", buf_avalid, '0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        areset = 1'b0;
        tick();

        // Basic 4-word save from bank 0
        run_op(6'b000001, 11'h010, 4, 256, 32'h0000_2000, 64'h0, 0, 0, 1, 0);

        // Backpressure window with junk on other banks
        noise_en = 1'b1;
        run_op(6'b000010, 11'h100, 16, 1024, 32'h1234_5678, 64'h10_0000_0000, 2, 0, 1, 0);

        // Group not one-hot
        run_op(6'b000110, 11'h020, 4, 256, 32'h0000_4000, 64'h0, 0, 0, 0, 1);

        // Block crossing the top of the bank; error flag clears on this start
        run_op(6'b000100, 11'h7FE, 4, 256, 32'h0000_8000, 64'h0, 0, 0, 1, 0);

        // Reset in the middle of a stream, then restart on bank 3
        start_op(6'b000001, 11'h040, 16, 1024, 32'h0, 64'h0, 1);
        m_axis_tready = 1'b0;
        repeat (12) tick();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        check("abort_busy", ap_busy, 1'b0);
        check("abort_tvalid", m_axis_tvalid, 1'b0);
        check("abort_avalid", buf_avalid, '0);
        check("abort_no_done", n_done, 0);
        check("abort_credit", max_infl <= 8, 1'b1);
        m_axis_tready = 1'b1;
        repeat (10) tick();
        run_op(6'b001000, 11'h300, 8, 512, 32'h0000_C000, 64'h0, 1, 0, 1, 0);

        // Offset wrap and zero-byte instruction
        run_op(6'b000001, 11'h000, 4, 0, 32'h0000_1000, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, 0);

        // len 0 with nonzero bytes: launch, no reads
        run_op(6'b000001, 11'h050, 0, 64, 32'h0000_0040, 64'h0, 0, 0, 1, 0);

        // Group bit beyond the implemented banks
        run_op(6'b010000, 11'h050, 4, 256, 32'h0000_0080, 64'h0, 0, 0, 0, 1);

        // Randomized instructions
        for (int t = 0; t < 10; t++) begin
            int b;
            b = int'($urandom_range(0, NB - 1));
            lat = int'($urandom_range(1, 6));
            repeat (2) tick();
            run_op(6'(1 << b), 11'($urandom), int'($urandom_range(1, 24)),
                   int'($urandom_range(1, 65535)), $urandom, {$urandom, $urandom},
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
